// File: rtl/vigna_bus_arbiter_if.sv
// Bundles the instruction, data and memory-side handshake signals of the vigna bus arbiter.
// The master modport is the arbiter's view; the slave modport is the view of the core and memory around it.
interface vigna_bus_arbiter_if;
   logic        i_valid;
   logic        i_ready;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        d_valid;
   logic        d_ready;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] d_rdata;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
      output i_ready, i_rdata, d_ready, d_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, mem_ready, mem_rdata,
      input  i_ready, i_rdata, d_ready, d_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/vigna_bus_arbiter.sv
// Shares one memory port between the vigna instruction and data ports, one transfer at a time,
// with an optional watchdog that aborts stalled transfers and raises a sticky bus error.
module vigna_bus_arbiter #(
   parameter int ROUND_ROBIN = 1,
   parameter int TIMEOUT     = 0,
   parameter int CNT_W       = 8
) (
   input  logic                clk,
   input  logic                resetn,
   vigna_bus_arbiter_if.master bus,
   output logic                bus_err,
   input  logic                err_clr
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   state_t            state_q, state_d;
   logic              last_d_q, last_d_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              err_q, err_d;

   logic busy, abort, done, grant_d, grant_i;
   logic [31:0] rdata;

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      err_d    = err_q;

      busy  = (state_q != IDLE);
      abort = (TIMEOUT != 0) && busy && (cnt_q == TO_LAST) && !bus.mem_ready;
      done  = busy && (bus.mem_ready || abort);
      // Round robin hands a tie to whichever port was not served last.
      grant_d = bus.d_valid && (!bus.i_valid || (ROUND_ROBIN == 0) || !last_d_q);
      grant_i = bus.i_valid && !grant_d;

      case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d  = D_BUSY;
               addr_d   = bus.d_addr;
               wdata_d  = bus.d_wdata;
               wstrb_d  = bus.d_wstrb;
               valid_d  = 1'b1;
               last_d_d = 1'b1;
               cnt_d    = '0;
            end else if (grant_i) begin
               state_d  = I_BUSY;
               addr_d   = bus.i_addr;
               wdata_d  = 32'h0;
               wstrb_d  = 4'h0;
               valid_d  = 1'b1;
               last_d_d = 1'b0;
               cnt_d    = '0;
            end
         end
         I_BUSY, D_BUSY: begin
            if (done) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // An abort in the same cycle as a clear must leave the error set.
      if (abort)        err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;

      rdata = (busy && bus.mem_ready) ? bus.mem_rdata : 32'h0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         wstrb_q  <= 4'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         err_q    <= err_d;
      end
   end

   assign bus.i_ready   = (state_q == I_BUSY) && done;
   assign bus.d_ready   = (state_q == D_BUSY) && done;
   assign bus.i_rdata   = rdata;
   assign bus.d_rdata   = rdata;
   assign bus.mem_valid = valid_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wstrb = wstrb_q;
   assign bus_err       = err_q;

endmodule
